gb_bus_tracer: RTL and testbench
================================

Name: gb_bus_tracer

Overview:
- Consumes the registered Game Boy cartridge-bus samples produced by the FPGA top level: adr_in, data_in, nrd, nwr, ncs.
- Turns completed read and write strobes into timestamped trace entries and buffers them in a FIFO.
- Presents the entries on a valid/ready stream to a downstream consumer (LED display, UART dumper).
- Purpose: observe the exact bus cycle at which an overclocked tick corrupts CPU behaviour.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..256.
- TS_WIDTH, 25, width of the Game Boy clock-tick timestamp counter.
- MIN_LOW, 2, minimum consecutive low samples for a strobe to count as valid (glitch filter); 1..15.
- CAPTURE_READS, 1, when 0 read strobes are ignored and only writes are traced.

Ports:
- clk, in, 1, FPGA system clock (PLL output).
- reset, in, 1, asynchronous active-high reset.
- adr_in, in, 15, sampled A0–A14.
- ncs, in, 1, sampled A15 / ROM chip select, active low.
- nrd, in, 1, sampled read strobe, active low.
- nwr, in, 1, sampled write strobe, active low.
- data_in, in, 8, sampled data bus.
- gb_tick, in, 1, one-cycle pulse per rising edge of the Game Boy clock.
- ts_clr, in, 1, synchronous clear of the timestamp counter.
- ovf_clr, in, 1, synchronous clear of overflow flag and drop counter.
- out_valid, out, 1, an entry is available.
- out_ready, in, 1, consumer accepts the entry.
- out_is_wr, out, 1, 1 = write entry, 0 = read entry.
- out_adr, out, 16, {ncs-inverted A15, adr[14:0]}.
- out_data, out, 8, captured data byte.
- out_ts, out, TS_WIDTH, timestamp at strobe release.
- overflow, out, 1, sticky: at least one entry dropped.
- drop_cnt, out, 8, count of dropped entries, saturating at 255.
- level, out, clog2(DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset (async, active-high):
  - FIFO empty; out_valid=0; out_is_wr/out_adr/out_data/out_ts=0.
  - overflow=0; drop_cnt=0; level=0; timestamp=0.
  - Both strobe trackers go to ARM.
- Timestamp:
  - Increments modulo 2^TS_WIDTH on each gb_tick.
  - ts_clr has priority over gb_tick and sets it to 0.
- Strobe tracker: one per strobe (rd, wr), states ARM, IDLE, LOW.
  - ARM: wait for the strobe sampled high, then go to IDLE. A strobe already low when reset deasserts is never traced.
  - IDLE: strobe low → LOW with lowcnt=1. Latch adr_in, ncs, data_in every cycle the strobe is low, so the latch holds the last-low-cycle values.
  - LOW: strobe low → lowcnt increments, saturating at 15. Strobe high → event if lowcnt >= MIN_LOW, else discarded as glitch; go to IDLE either way.
- Event content:
  - Entry = {is_wr, adr16, data = last-low-cycle data_in, ts = timestamp in the release cycle}.
  - adr16[15] = !ncs latched.
- Conflicts:
  - nwr and nrd both low: write tracker runs normally; read tracker is forced back to IDLE without an event.
  - Read and write releasing in the same cycle: only the write entry is pushed.
  - CAPTURE_READS=0: read tracker held in IDLE.
- Latency:
  - Release detected in cycle N → entry written at the end of N.
  - Into an empty FIFO, out_valid=1 in cycle N+1.
- FIFO and stream:
  - First-word-fall-through; out_* stable while out_valid=1 and out_ready=0.
  - Pop on out_valid && out_ready.
- Full and overflow:
  - Push when full without a same-cycle pop → entry dropped, overflow set, drop_cnt++ (saturating).
  - Push and pop in the same cycle while full → push accepted, level unchanged.
  - ovf_clr clears overflow and drop_cnt. An overflow in the same cycle as ovf_clr wins: overflow=1, drop_cnt=1.
- Pointers wrap modulo DEPTH. level counts 0..DEPTH.

Decomposition:
- Package gb_trace_pkg:
  - Entry struct (is_wr, adr[15:0], data[7:0], ts).
  - Constants KIND_RD=0, KIND_WR=1.
  - Tracker state enum {ARM, IDLE, LOW}.
- Sub-module gb_trace_fifo: generic synchronous FWFT FIFO with DEPTH and entry-width parameters, full/empty/level outputs, and a same-cycle push+pop-when-full rule.
- The two trackers are inline instances of one always-block pattern; no separate module.

Test Plan:
- Reset release with nwr=0, then nwr high, then a 3-cycle write to 0x01ff data 0x31 with ncs=0 → exactly one entry: is_wr=1, adr=0x81ff, data=0x31.
- nrd low for 1 cycle (MIN_LOW=2), then nrd low 4 cycles at adr 0x0100 data 0x00 → one read entry only, ts equal to the tick count at release; 1-cycle pulse ignored.
- Reads and writes with out_ready=0 until 16 entries are queued, then one more write → level=16, overflow=1, drop_cnt=1. The 17th is absent after draining all 16 in order.
- Full FIFO, out_ready=1 and a write release in the same cycle → level stays 16, overflow stays 0, the new entry appears last.
- 300 dropped events, then ovf_clr → drop_cnt saturates at 255; ovf_clr clears both flags; gb_tick and ts_clr in the same cycle → ts=0.
- Reset asserted mid-strobe with 5 entries queued → out_valid=0 and level=0 immediately. The strobe in progress at deassert yields no entry; the next full strobe is traced.

Source files
------------

// File: rtl/gb_trace_pkg.sv
// -----------------------------------------------------------------------------
// gb_trace_pkg
//   Shared types and constants for the Game Boy cartridge-bus tracer.
//   - KIND_RD / KIND_WR : entry kind, also the index of each strobe tracker
//   - trk_state_e       : strobe tracker states (ARM, IDLE, LOW)
//   - trace_hdr_t       : fixed-width part of a trace entry (kind, address,
//                         data); the top level appends a TS_WIDTH timestamp
//   - sat_inc4          : 4-bit saturating increment for the low-cycle counter
// -----------------------------------------------------------------------------
package gb_trace_pkg;

    localparam logic KIND_RD = 1'b0;
    localparam logic KIND_WR = 1'b1;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        LOW  = 2'd2
    } trk_state_e;

    typedef struct packed {
        logic        is_wr;
        logic [15:0] adr;
        logic [7:0]  data;
    } trace_hdr_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/gb_trace_fifo.sv
// -----------------------------------------------------------------------------
// gb_trace_fifo
//   Generic synchronous first-word-fall-through FIFO.
//   Ports:
//     clk, reset    : clock, asynchronous active-high reset
//     push, din     : write request and data (ignored when full unless a pop
//                     happens in the same cycle)
//     pop           : consume the head entry (ignored when empty)
//     dout          : head entry, forced to zero while empty
//     full, empty   : occupancy flags
//     level         : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module gb_trace_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_LVL);
    assign level = cnt_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        pop_ok = pop && !empty;
        // A pop frees the slot this same cycle, so a full FIFO still accepts.
        push_ok  = push && (!full || pop_ok);
        // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        cnt_d    = cnt_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: storage is deliberately not reset; cnt_q decides which words are
    // valid, and a reset-free array can map onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/gb_bus_tracer.sv
// -----------------------------------------------------------------------------
// gb_bus_tracer
//   Turns completed Game Boy cartridge-bus read/write strobes into timestamped
//   trace entries, buffers them and streams them out on valid/ready.
//   Ports:
//     clk, reset              : system clock, asynchronous active-high reset
//     adr_in, ncs, nrd, nwr,
//     data_in                 : registered bus samples (strobes active low)
//     gb_tick                 : one pulse per Game Boy clock rising edge
//     ts_clr                  : clear timestamp (beats gb_tick)
//     ovf_clr                 : clear overflow flag and drop counter
//     out_valid/out_ready     : entry stream handshake
//     out_is_wr, out_adr,
//     out_data, out_ts        : head entry fields
//     overflow, drop_cnt      : sticky drop flag, saturating drop count
//     level                   : FIFO occupancy
// -----------------------------------------------------------------------------
module gb_bus_tracer #(
    parameter int DEPTH         = 16,
    parameter int TS_WIDTH      = 25,
    parameter int MIN_LOW       = 2,
    parameter int CAPTURE_READS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [14:0]             adr_in,
    input  logic                    ncs,
    input  logic                    nrd,
    input  logic                    nwr,
    input  logic [7:0]              data_in,
    input  logic                    gb_tick,
    input  logic                    ts_clr,
    input  logic                    ovf_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_is_wr,
    output logic [15:0]             out_adr,
    output logic [7:0]              out_data,
    output logic [TS_WIDTH-1:0]     out_ts,
    output logic                    overflow,
    output logic [7:0]              drop_cnt,
    output logic [$clog2(DEPTH):0]  level
);

    import gb_trace_pkg::*;

    typedef struct packed {
        trace_hdr_t          hdr;
        logic [TS_WIDTH-1:0] ts;
    } entry_t;

    localparam int EW = $bits(entry_t);

    // Tracker arrays are indexed by KIND_RD / KIND_WR.
    trk_state_e          state_q  [2];
    trk_state_e          state_d  [2];
    logic [3:0]          lowcnt_q [2];
    logic [3:0]          lowcnt_d [2];
    logic [14:0]         ladr_q   [2];
    logic [14:0]         ladr_d   [2];
    logic                lncs_q   [2];
    logic                lncs_d   [2];
    logic [7:0]          ldata_q  [2];
    logic [7:0]          ldata_d  [2];
    logic [1:0]          strb_n;
    logic [1:0]          evt;

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;

    logic                sel, push, pop, drop, full, empty;
    entry_t              push_entry, pop_entry;

    assign strb_n = {nwr, nrd};

    // ---------------- strobe trackers ----------------
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            // NOTE: every output gets a default before the case so no path
            // leaves a variable unassigned (which would infer a latch).
            state_d[k]  = state_q[k];
            lowcnt_d[k] = lowcnt_q[k];
            ladr_d[k]   = ladr_q[k];
            lncs_d[k]   = lncs_q[k];
            ldata_d[k]  = ldata_q[k];
            evt[k]      = 1'b0;

            case (state_q[k])
                // A strobe already low out of reset must be seen high first.
                ARM: if (strb_n[k]) state_d[k] = IDLE;
                IDLE: begin
                    if (!strb_n[k]) begin
                        state_d[k]  = LOW;
                        lowcnt_d[k] = 4'd1;
                    end
                end
                LOW: begin
                    if (!strb_n[k]) begin
                        lowcnt_d[k] = sat_inc4(lowcnt_q[k]);
                    end else begin
                        evt[k]     = (lowcnt_q[k] >= 4'(MIN_LOW));
                        state_d[k] = IDLE;
                    end
                end
                default: state_d[k] = ARM;
            endcase

            // Keep overwriting while low so the release sees the last-low values.
            if (!strb_n[k]) begin
                ladr_d[k]  = adr_in;
                lncs_d[k]  = ncs;
                ldata_d[k] = data_in;
            end
        end

        // Both strobes low is not a valid read; the write wins.
        if (!nrd && !nwr && state_q[KIND_RD] != ARM) begin
            state_d[KIND_RD] = IDLE;
        end

        if (CAPTURE_READS == 0) begin
            state_d[KIND_RD] = IDLE;
            evt[KIND_RD]     = 1'b0;
        end
    end

    // ---------------- entry assembly ----------------
    always_comb begin
        sel                 = evt[KIND_WR] ? KIND_WR : KIND_RD;
        push                = |evt;
        push_entry.hdr.is_wr = sel;
        push_entry.hdr.adr   = {~lncs_q[sel], ladr_q[sel]};
        push_entry.hdr.data  = ldata_q[sel];
        push_entry.ts        = ts_q;
    end

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign drop      = push && full && !pop;

    // ---------------- timestamp and overflow ----------------
    always_comb begin
        if (ts_clr)       ts_d = '0;
        else if (gb_tick) ts_d = ts_q + TS_WIDTH'(1);
        else              ts_d = ts_q;

        overflow_d = ovf_clr ? 1'b0 : overflow_q;
        drop_cnt_d = ovf_clr ? 8'd0 : drop_cnt_q;
        // A drop in the clear cycle survives the clear.
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != 8'hff) drop_cnt_d = drop_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                state_q[k]  <= ARM;
                lowcnt_q[k] <= '0;
                ladr_q[k]   <= '0;
                lncs_q[k]   <= 1'b1;
                ldata_q[k]  <= '0;
            end
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                state_q[k]  <= state_d[k];
                lowcnt_q[k] <= lowcnt_d[k];
                ladr_q[k]   <= ladr_d[k];
                lncs_q[k]   <= lncs_d[k];
                ldata_q[k]  <= ldata_d[k];
            end
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // ---------------- FIFO ----------------
    gb_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (pop_entry),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign out_is_wr = pop_entry.hdr.is_wr;
    assign out_adr   = pop_entry.hdr.adr;
    assign out_data  = pop_entry.hdr.data;
    assign out_ts    = pop_entry.ts;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_gb_bus_tracer.sv
`timescale 1ns/1ps
module tb_gb_bus_tracer;

    localparam int DEPTH    = 16;
    localparam int TS_WIDTH = 25;
    localparam int MIN_LOW  = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [14:0]         adr_in = '0;
    logic                ncs = 1'b1, nrd = 1'b1, nwr = 1'b1;
    logic [7:0]          data_in = '0;
    logic                gb_tick = 1'b0, ts_clr = 1'b0, ovf_clr = 1'b0;
    logic                out_ready = 1'b0;
    logic                out_valid, out_is_wr, overflow;
    logic [15:0]         out_adr;
    logic [7:0]          out_data, drop_cnt;
    logic [TS_WIDTH-1:0] out_ts;
    logic [4:0]          level;

    typedef struct {
        logic                is_wr;
        logic [15:0]         adr;
        logic [7:0]          data;
        logic [TS_WIDTH-1:0] ts;
    } exp_t;

    exp_t                sb[$];
    int                  n_vec = 0;
    int                  n_bad = 0;
    logic [TS_WIDTH-1:0] ts_m = '0;

    always #5 clk = ~clk;

    gb_bus_tracer #(
        .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH), .MIN_LOW(MIN_LOW), .CAPTURE_READS(1)
    ) dut (
        .clk(clk), .reset(reset), .adr_in(adr_in), .ncs(ncs), .nrd(nrd),
        .nwr(nwr), .data_in(data_in), .gb_tick(gb_tick), .ts_clr(ts_clr),
        .ovf_clr(ovf_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_is_wr(out_is_wr), .out_adr(out_adr), .out_data(out_data),
        .out_ts(out_ts), .overflow(overflow), .drop_cnt(drop_cnt), .level(level)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every accepted stream entry must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_entry: got wr=%0b adr=%h data=%h ts=%0d, want none",
                         out_is_wr, out_adr, out_data, out_ts);
            end else begin
                e = sb.pop_front();
                if ({out_is_wr, out_adr, out_data, out_ts} !== {e.is_wr, e.adr, e.data, e.ts}) begin
                    n_bad++;
                    $display("FAIL entry: got wr=%0b adr=%h data=%h ts=%0d, want wr=%0b adr=%h data=%h ts=%0d",
                             out_is_wr, out_adr, out_data, out_ts, e.is_wr, e.adr, e.data, e.ts);
                end
            end
        end
    end

    // One clock; inputs change 1 ns after the edge. ts_m tracks the counter.
    task automatic step();
        @(posedge clk);
        if (reset || ts_clr) ts_m = '0;
        else if (gb_tick)    ts_m = ts_m + 1'b1;
        #1;
    endtask

    // Drive one strobe of low_n cycles followed by its release cycle.
    task automatic do_strobe(input logic is_wr, input logic [15:0] adr, input logic [7:0] data,
                             input int low_n, input bit exp_push, input bit rdy_rel);
        logic save_rdy;
        exp_t e;
        adr_in = adr[14:0];
        ncs    = ~adr[15];
        for (int i = 0; i < low_n; i++) begin
            data_in = (i == low_n - 1) ? data : ~data;
            if (is_wr) nwr = 1'b0; else nrd = 1'b0;
            step();
        end
        nwr = 1'b1;
        nrd = 1'b1;
        data_in = data ^ 8'h5a;
        e = '{is_wr, adr, data, ts_m};
        if (exp_push) sb.push_back(e);
        save_rdy = out_ready;
        if (rdy_rel) out_ready = 1'b1;
        step();
        out_ready = save_rdy;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) step();
        n_vec++;
        if (sb.size() != 0 || level !== 5'd0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d pending, level %0d, want 0 and 0", tag, sb.size(), level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        nwr = 1'b0;
        repeat (3) step();
        @(negedge clk);
        n_vec++;
        if ({out_valid, overflow, drop_cnt, level} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_flags: got valid=%b ovf=%b drop=%0d level=%0d, want all 0",
                     out_valid, overflow, drop_cnt, level);
        end
        n_vec++;
        if ({out_is_wr, out_adr, out_data, out_ts} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got wr=%b adr=%h data=%h ts=%0d, want all 0",
                     out_is_wr, out_adr, out_data, out_ts);
        end
        step();
        reset = 1'b0;
        repeat (3) step();
        nwr = 1'b1;
        repeat (2) step();
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_armed: got valid=%b, want 0", out_valid);
        end
        do_strobe(1'b1, 16'h81ff, 8'h31, 3, 1'b1, 1'b0);
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || level !== 5'd1) begin
            n_bad++;
            $display("FAIL first_latency: got valid=%b level=%0d, want 1 and 1", out_valid, level);
        end
        drain("reset");
    endtask

    task automatic test_glitch();
        ts_clr = 1'b1;
        step();
        ts_clr  = 1'b0;
        gb_tick = 1'b1;
        do_strobe(1'b0, 16'h8100, 8'hc3, 1, 1'b0, 1'b0);
        do_strobe(1'b0, 16'h8100, 8'h00, 4, 1'b1, 1'b0);
        gb_tick = 1'b0;
        @(negedge clk);
        n_vec++;
        if (level !== 5'd1) begin
            n_bad++;
            $display("FAIL glitch_level: got %0d, want 1", level);
        end
        drain("glitch");
    endtask

    task automatic test_conflict();
        exp_t e;
        adr_in = 15'h2000; ncs = 1'b1; data_in = 8'h77;
        nrd = 1'b0; nwr = 1'b0;
        repeat (3) step();
        nrd = 1'b1; nwr = 1'b1; data_in = 8'h00;
        e = '{1'b1, 16'h2000, 8'h77, ts_m};
        sb.push_back(e);
        step();
        do_strobe(1'b0, 16'h8abc, 8'h9e, 2, 1'b1, 1'b0);
        drain("conflict");
    endtask

    task automatic fill16();
        logic [15:0] a;
        for (int i = 0; i < 16; i++) begin
            a = {i[0], 15'h0100 + 15'(i)};
            do_strobe(i[0], a, 8'(i * 7 + 3), 2 + (i % 3), 1'b1, 1'b0);
        end
    endtask

    task automatic test_overflow();
        fill16();
        do_strobe(1'b1, 16'h7777, 8'hee, 2, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (level !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL overflow: got level=%0d ovf=%b drop=%0d, want 16 1 1", level, overflow, drop_cnt);
        end
        drain("overflow");
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge clk);
        n_vec++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL ovf_clear: got ovf=%b drop=%0d, want 0 0", overflow, drop_cnt);
        end
    endtask

    task automatic test_back_to_back();
        fill16();
        do_strobe(1'b1, 16'h9abc, 8'h5c, 3, 1'b1, 1'b1);
        @(negedge clk);
        n_vec++;
        if (level !== 5'd16 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL push_pop_full: got level=%0d ovf=%b, want 16 0", level, overflow);
        end
        drain("push_pop");
    endtask

    task automatic test_saturate();
        fill16();
        for (int i = 0; i < 300; i++) do_strobe(1'b1, 16'h1234, 8'(i), 2, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_saturate: got drop=%0d ovf=%b, want 255 1", drop_cnt, overflow);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge clk);
        n_vec++;
        if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_clear: got drop=%0d ovf=%b, want 0 0", drop_cnt, overflow);
        end
        nwr = 1'b0;
        repeat (2) step();
        nwr = 1'b1; ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge clk);
        n_vec++;
        if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_vs_drop: got drop=%0d ovf=%b, want 1 1", drop_cnt, overflow);
        end
        drain("saturate");
        gb_tick = 1'b1;
        repeat (5) step();
        ts_clr = 1'b1;
        step();
        gb_tick = 1'b0; ts_clr = 1'b0;
        do_strobe(1'b1, 16'h8042, 8'ha5, 2, 1'b1, 1'b0);
        @(negedge clk);
        n_vec++;
        if (out_ts !== '0) begin
            n_bad++;
            $display("FAIL ts_clr_priority: got ts=%0d, want 0", out_ts);
        end
        drain("ts_clr");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) do_strobe(1'b1, 16'h8300 + 16'(i), 8'(8'h40 + i), 2, 1'b1, 1'b0);
        @(negedge clk);
        n_vec++;
        if (level !== 5'd5) begin
            n_bad++;
            $display("FAIL pre_reset_level: got %0d, want 5", level);
        end
        adr_in = 15'h0055; ncs = 1'b0; nwr = 1'b0;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            n_bad++;
            $display("FAIL async_reset: got valid=%b level=%0d, want 0 0", out_valid, level);
        end
        sb.delete();
        ts_m = '0;
        repeat (2) step();
        reset = 1'b0;
        repeat (2) step();
        nwr = 1'b1;
        repeat (2) step();
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_strobe_ignored: got valid=%b, want 0", out_valid);
        end
        do_strobe(1'b1, 16'h80aa, 8'h11, 2, 1'b1, 1'b0);
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_conflict();
        test_overflow();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
